// File: rtl/life_board_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// life_board_ctrl_pkg
// Shared constants and types for the 8x8 Game-of-Life board controller.
//   BOARD_W        : number of cells on the board (8 x 8)
//   ROW_LEN        : cells per row; cell (r, c) lives at bit r*ROW_LEN + c
//   INTERIOR_MASK  : 1 for the 6x6 interior; the outer ring is held at 0
//   run_state_e    : controller state encoding, also exported as run_state
// -----------------------------------------------------------------------------
package life_board_ctrl_pkg;

    localparam int BOARD_W = 64;
    localparam int ROW_LEN = 8;

    // The neighbour-count stage only produces interior cells, so the border
    // ring is forced to zero whenever the board register is written.
    localparam logic [BOARD_W-1:0] INTERIOR_MASK = 64'h007E_7E7E_7E7E_7E00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } run_state_e;

    function automatic logic [BOARD_W-1:0] mask_interior(input logic [BOARD_W-1:0] b);
        return b & INTERIOR_MASK;
    endfunction

endpackage

// File: rtl/life_board_ctrl_if.sv
// -----------------------------------------------------------------------------
// life_board_ctrl_if
// Bundles every signal between the board controller and its environment.
//   load_valid/load_data/load_ready : initial-pattern handshake
//   start/pause/step/clear          : one-cycle control pulses
//   next                            : next-generation board from upstream
//   arr                             : current board
//   gen_count/gen_strobe            : generation counter and commit pulse
//   stable/extinct                  : board status flags
//   run_state                       : controller state (0 IDLE, 1 RUN, 2 PAUSED)
//
// Handshake: a pattern transfers on a posedge where load_valid && load_ready
// are both high. The offerer holds load_data stable while load_valid is high;
// load_ready never depends on load_valid.
//
// Modports: master = environment side, slave = controller side.
// -----------------------------------------------------------------------------
interface life_board_ctrl_if #(
    parameter int GEN_W = 16
);
    logic             load_valid;
    logic [63:0]      load_data;
    logic             load_ready;
    logic             start;
    logic             pause;
    logic             step;
    logic             clear;
    logic [63:0]      next;
    logic [63:0]      arr;
    logic [GEN_W-1:0] gen_count;
    logic             gen_strobe;
    logic             stable;
    logic             extinct;
    logic [1:0]       run_state;

    modport master (
        output load_valid, load_data, start, pause, step, clear, next,
        input  load_ready, arr, gen_count, gen_strobe, stable, extinct, run_state
    );

    modport slave (
        input  load_valid, load_data, start, pause, step, clear, next,
        output load_ready, arr, gen_count, gen_strobe, stable, extinct, run_state
    );
endinterface

// File: rtl/life_tick_div.sv
// -----------------------------------------------------------------------------
// life_tick_div
// Generation-rate divider. Counts only while en is high and ticks on the
// cycle the count equals DIV-1, then wraps to 0. restart zeroes the count.
//   clk, rst_n : clock and synchronous active-low reset
//   en         : count enable
//   restart    : force count to 0 on the next edge
//   tick       : high for one cycle every DIV enabled cycles
// -----------------------------------------------------------------------------
module life_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/life_board_ctrl.sv
// -----------------------------------------------------------------------------
// life_board_ctrl
// Holds the 8x8 Game-of-Life board and decides when the next generation from
// the upstream neighbour-count stage is committed.
//   clk   : clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : life_board_ctrl_if.slave (load handshake, controls, next, status)
// Parameters:
//   TICK_DIV : clk cycles per generation while running (>= 2)
//   NEXT_LAT : cycles from an arr change until next is valid
//   GEN_W    : generation counter width
// -----------------------------------------------------------------------------
module life_board_ctrl
    import life_board_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int NEXT_LAT = 1,
    parameter int GEN_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    life_board_ctrl_if.slave    bus
);

    localparam int            SW          = (NEXT_LAT > 1) ? $clog2(NEXT_LAT + 1) : 1;
    localparam logic [SW-1:0] SETTLE_DONE = SW'(NEXT_LAT);

    run_state_e          state_q, state_d;
    logic [BOARD_W-1:0]  arr_q, arr_d;
    logic [GEN_W-1:0]    gen_q, gen_d;
    logic                stable_q, stable_d;
    logic                pend_q, pend_d;
    logic                strobe_q;
    logic [SW-1:0]       settle_cnt;

    logic                commit;
    logic                do_load;
    logic                load_ready;
    logic                settled;
    logic                tick;
    logic                run_entry;
    logic [BOARD_W-1:0]  next_m;
    logic                next_same;

    assign next_m    = mask_interior(bus.next);
    assign next_same = (next_m == arr_q);
    assign settled   = (settle_cnt >= SETTLE_DONE);

    // Any control pulse outranks the load, so the handshake only offers
    // ready on cycles where a load would actually be taken.
    assign load_ready = ((state_q == ST_IDLE) || (state_q == ST_PAUSED)) &&
                        !(bus.clear || bus.pause || bus.start || bus.step);
    assign do_load    = bus.load_valid && load_ready;

    assign run_entry  = (state_d == ST_RUN) && (state_q != ST_RUN);

    life_tick_div #(
        .DIV (TICK_DIV)
    ) u_tick_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (state_q == ST_RUN),
        .restart (run_entry),
        .tick    (tick)
    );

    always_comb begin
        state_d  = state_q;
        arr_d    = arr_q;
        gen_d    = gen_q;
        stable_d = stable_q;
        pend_d   = 1'b0;
        commit   = 1'b0;

        if (bus.clear) begin
            state_d  = ST_IDLE;
            arr_d    = '0;
            gen_d    = '0;
            stable_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.pause && bus.start) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSED;
                    end else begin
                        // A tick that arrives before next is valid is held
                        // and served on the first settled cycle.
                        commit = (tick || pend_q) && settled;
                        pend_d = (tick || pend_q) && !settled;
                        if (commit && next_same) state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSED;
                    end else if (bus.start) begin
                        state_d = ST_RUN;
                    end else if (bus.step && settled) begin
                        commit = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (commit) begin
                arr_d    = next_m;
                gen_d    = (&gen_q) ? gen_q : gen_q + GEN_W'(1);
                stable_d = next_same;
            end else if (do_load) begin
                arr_d    = mask_interior(bus.load_data);
                gen_d    = '0;
                stable_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            arr_q    <= '0;
            gen_q    <= '0;
            stable_q <= 1'b0;
            pend_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            arr_q    <= arr_d;
            gen_q    <= gen_d;
            stable_q <= stable_d;
            pend_q   <= pend_d;
            strobe_q <= commit;
        end
    end

    // Settle counter: restarts whenever the board value changes and stops
    // once NEXT_LAT cycles have passed, at which point next is trusted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (arr_d != arr_q) begin
            settle_cnt <= '0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + SW'(1);
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.arr        = arr_q;
    assign bus.gen_count  = gen_q;
    assign bus.gen_strobe = strobe_q;
    assign bus.stable     = stable_q;
    assign bus.extinct    = (arr_q == '0);
    assign bus.run_state  = state_q;

endmodule

// File: tb/tb_life_board_ctrl.sv
module tb_life_board_ctrl;

    localparam logic [63:0] BLINK_H  = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V  = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK    = 64'h0000_0018_1800_0000;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INTERIOR = 64'h007E_7E7E_7E7E_7E00;
    localparam logic [63:0] RING     = 64'hFF81_8181_8181_81FF;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    life_board_ctrl_if #(.GEN_W(4)) bus ();

    life_board_ctrl #(
        .TICK_DIV (4),
        .NEXT_LAT (1),
        .GEN_W    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Neighbour-count stage: registered, so next is valid one cycle after
    // each arr change. Interior cells only.
    function automatic logic [63:0] life_next(input logic [63:0] b);
        logic [63:0] n;
        int          cnt;
        n = '0;
        for (int r = 1; r < 7; r++) begin
            for (int c = 1; c < 7; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (!(dr == 0 && dc == 0)) cnt += int'(b[(r + dr) * 8 + (c + dc)]);
                    end
                end
                n[r * 8 + c] = (cnt == 3) || (cnt == 2 && b[r * 8 + c]);
            end
        end
        return n;
    endfunction

    always @(posedge clk) bus.next <= life_next(bus.arr);

    // Driver tasks
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] d);
        bus.load_valid = 1'b1;
        bus.load_data  = d;
        cyc(1);
        bus.load_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.step       = 1'b0;
        bus.clear      = 1'b0;

        // Reset state
        cyc(3);
        chk("rst_arr",     bus.arr, 64'h0);
        chk("rst_gen",     64'(bus.gen_count), 64'h0);
        chk("rst_state",   64'(bus.run_state), 64'd0);
        chk("rst_strobe",  64'(bus.gen_strobe), 64'd0);
        chk("rst_stable",  64'(bus.stable), 64'd0);
        chk("rst_ready",   64'(bus.load_ready), 64'd1);
        chk("rst_extinct", 64'(bus.extinct), 64'd1);
        rst_n = 1'b1;
        cyc(2);

        // Border mask
        do_load(ALL_ONES);
        chk("mask_all_arr",  bus.arr, INTERIOR);
        chk("mask_all_ext",  64'(bus.extinct), 64'd0);
        chk("mask_state",    64'(bus.run_state), 64'd0);
        do_load(RING);
        chk("mask_ring_arr", bus.arr, 64'h0);
        chk("mask_ring_ext", 64'(bus.extinct), 64'd1);

        // Blinker in RUN: commits on the 4th cycle after start
        do_load(BLINK_H);
        chk("blink_load", bus.arr, BLINK_H);
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        chk("blink_run", 64'(bus.run_state), 64'd1);
        cyc(3);
        chk("blink_pre1_strobe", 64'(bus.gen_strobe), 64'd0);
        chk("blink_pre1_arr",    bus.arr, BLINK_H);
        cyc(1);
        chk("blink_c1_arr",    bus.arr, BLINK_V);
        chk("blink_c1_strobe", 64'(bus.gen_strobe), 64'd1);
        chk("blink_c1_gen",    64'(bus.gen_count), 64'd1);
        cyc(3);
        chk("blink_pre2_strobe", 64'(bus.gen_strobe), 64'd0);
        cyc(1);
        chk("blink_c2_arr",    bus.arr, BLINK_H);
        chk("blink_c2_gen",    64'(bus.gen_count), 64'd2);
        chk("blink_c2_stable", 64'(bus.stable), 64'd0);
        chk("blink_c2_strobe", 64'(bus.gen_strobe), 64'd1);

        // Step in RUN adds no commit
        bus.step = 1'b1; cyc(1); bus.step = 1'b0;
        cyc(2);
        chk("runstep_gen",    64'(bus.gen_count), 64'd2);
        chk("runstep_strobe", 64'(bus.gen_strobe), 64'd0);
        cyc(1);
        chk("blink_c3_gen", 64'(bus.gen_count), 64'd3);
        chk("blink_c3_arr", bus.arr, BLINK_V);

        // Pause, then start+pause together stays PAUSED
        bus.pause = 1'b1; cyc(1); bus.pause = 1'b0;
        chk("pause_state", 64'(bus.run_state), 64'd2);
        bus.start = 1'b1; bus.pause = 1'b1; cyc(1);
        bus.start = 1'b0; bus.pause = 1'b0;
        chk("startpause_state", 64'(bus.run_state), 64'd2);
        chk("startpause_gen",   64'(bus.gen_count), 64'd3);

        // Step in PAUSED: exactly one commit
        bus.step = 1'b1; cyc(1); bus.step = 1'b0;
        chk("step_strobe", 64'(bus.gen_strobe), 64'd1);
        chk("step_gen",    64'(bus.gen_count), 64'd4);
        chk("step_arr",    bus.arr, BLINK_H);
        cyc(1);
        chk("step_strobe_off", 64'(bus.gen_strobe), 64'd0);
        cyc(3);
        chk("step_gen_hold", 64'(bus.gen_count), 64'd4);

        // Load offered while running is refused
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        chk("run2_state", 64'(bus.run_state), 64'd1);
        bus.load_valid = 1'b1; bus.load_data = BLOCK;
        #1;
        chk("run_load_ready", 64'(bus.load_ready), 64'd0);
        cyc(1);
        bus.load_valid = 1'b0;
        chk("run_load_arr", bus.arr, BLINK_H);

        // Clear during RUN
        bus.clear = 1'b1; cyc(1); bus.clear = 1'b0;
        chk("clear_arr",    bus.arr, 64'h0);
        chk("clear_state",  64'(bus.run_state), 64'd0);
        chk("clear_gen",    64'(bus.gen_count), 64'd0);
        chk("clear_strobe", 64'(bus.gen_strobe), 64'd0);

        // Block still life forces PAUSED after one commit
        do_load(BLOCK);
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        cyc(3);
        chk("block_pre_state", 64'(bus.run_state), 64'd1);
        cyc(1);
        chk("block_strobe", 64'(bus.gen_strobe), 64'd1);
        chk("block_stable", 64'(bus.stable), 64'd1);
        chk("block_state",  64'(bus.run_state), 64'd2);
        chk("block_gen",    64'(bus.gen_count), 64'd1);
        chk("block_arr",    bus.arr, BLOCK);

        // Generation counter saturates (4-bit counter here)
        for (int i = 0; i < 20; i++) begin
            bus.step = 1'b1; cyc(1); bus.step = 1'b0; cyc(1);
        end
        chk("sat_gen",   64'(bus.gen_count), 64'hF);
        chk("sat_state", 64'(bus.run_state), 64'd2);

        // Reset on a tick cycle mid-RUN discards the commit
        do_load(BLINK_H);
        chk("rl_gen", 64'(bus.gen_count), 64'd0);
        bus.start = 1'b1; cyc(1); bus.start = 1'b0;
        cyc(3);
        rst_n = 1'b0; cyc(1);
        chk("rstrun_arr",    bus.arr, 64'h0);
        chk("rstrun_state",  64'(bus.run_state), 64'd0);
        chk("rstrun_strobe", 64'(bus.gen_strobe), 64'd0);
        chk("rstrun_gen",    64'(bus.gen_count), 64'd0);
        rst_n = 1'b1;
        cyc(2);
        chk("rstrun_after_strobe", 64'(bus.gen_strobe), 64'd0);
        chk("rstrun_after_arr",    bus.arr, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
